// File: rtl/vga_timing_ctrl.sv
// VGA raster timing on the single board clock: pixel-enable divider, h/v counters,
// region state machines and registered sync / visible-area outputs.
module vga_timing_ctrl #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CNT_W     = 10
) (
    input  logic             clk_50mhz,
    input  logic             rst,
    output logic             pixel_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             video_on,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_FP_AT  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] H_SY_AT  = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_BP_AT  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_FP_AT  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] V_SY_AT  = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_BP_AT  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {HS_VIS, HS_FP, HS_SYNC, HS_BP} h_state_e;
    typedef enum logic [1:0] {VS_VIS, VS_FP, VS_SYNC, VS_BP} v_state_e;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    h_state_e         h_state_q, h_state_d;
    v_state_e         v_state_q, v_state_d;
    logic             video_on_q, video_on_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             tick_raw;
    logic             line_end;

    // The tick is decoded from the divider register; it is masked while reset is
    // held so a CLK_DIV=1 build still shows a quiet reset state.
    assign tick_raw    = (div_cnt_q == DIV_LAST);
    assign pixel_tick  = tick_raw && !rst;
    assign frame_start = pixel_tick && (h_q == H_LAST) && (v_q == V_LAST);
    assign line_end    = tick_raw && (h_q == H_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q;
        h_d       = h_q;
        v_d       = v_q;
        h_state_d = h_state_q;
        v_state_d = v_state_q;

        if (tick_raw) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        if (tick_raw) begin
            h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
            case (h_state_q)
                HS_VIS:  if (h_d == H_FP_AT) h_state_d = HS_FP;
                HS_FP:   if (h_d == H_SY_AT) h_state_d = HS_SYNC;
                HS_SYNC: if (h_d == H_BP_AT) h_state_d = HS_BP;
                HS_BP:   if (h_d == '0)      h_state_d = HS_VIS;
                default: h_state_d = HS_VIS;
            endcase
        end

        // The vertical side moves only when a line wraps.
        if (line_end) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            case (v_state_q)
                VS_VIS:  if (v_d == V_FP_AT) v_state_d = VS_FP;
                VS_FP:   if (v_d == V_SY_AT) v_state_d = VS_SYNC;
                VS_SYNC: if (v_d == V_BP_AT) v_state_d = VS_BP;
                VS_BP:   if (v_d == '0)      v_state_d = VS_VIS;
                default: v_state_d = VS_VIS;
            endcase
        end

        // Outputs are taken from next-state so they line up with the counters.
        video_on_d = (h_state_d == HS_VIS) && (v_state_d == VS_VIS);
        hsync_d    = (h_state_d != HS_SYNC);
        vsync_d    = (v_state_d != VS_SYNC);
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            div_cnt_q  <= '0;
            h_q        <= '0;
            v_q        <= '0;
            h_state_q  <= HS_VIS;
            v_state_q  <= VS_VIS;
            video_on_q <= 1'b1;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
        end else begin
            div_cnt_q  <= div_cnt_d;
            h_q        <= h_d;
            v_q        <= v_d;
            h_state_q  <= h_state_d;
            v_state_q  <= v_state_d;
            video_on_q <= video_on_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
        end
    end

    assign pixel_x  = h_q;
    assign pixel_y  = v_q;
    assign video_on = video_on_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;

endmodule
